// File: rtl/render_scheduler.sv
// rtl/render_scheduler.sv - Mandelbrot render sequencer and framebuffer port A owner
//
// Debounces the zoom button, keeps a saturating zoom level and, on every
// effective zoom change, clears the framebuffer, pulses the engine reset and
// forwards engine writes to BRAM port A until the engine reports ready.
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   btn_zoom          raw zoom button (asynchronous)
//   sw_dir            1 = zoom in, 0 = zoom out, sampled on a debounced press
//   eng_wea/addr/dout engine write port (forwarded only while rendering)
//   eng_ready         engine render-complete level
//   zoom_level        zoom level presented to the engine
//   eng_rst           engine reset, high during clear and reset pulse
//   bram_wea/addr/din registered BRAM port A
//   busy              high whenever not idle
//   frame_done        one-cycle pulse at the end of each render
//   timeout_err       sticky render-timeout flag
module render_scheduler #(
  parameter int          DEBOUNCE_CYCLES = 1000000,
  parameter int          FB_WORDS        = 120000,
  parameter int          ENG_RST_CYCLES  = 16,
  parameter int          TIMEOUT_CYCLES  = 67108864,
  parameter int          MAX_ZOOM        = 3,
  parameter logic [31:0] CLEAR_WORD      = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_zoom,
  input  logic        sw_dir,
  input  logic [3:0]  eng_wea,
  input  logic [16:0] eng_addr,
  input  logic [31:0] eng_dout,
  input  logic        eng_ready,
  output logic [1:0]  zoom_level,
  output logic        eng_rst,
  output logic [3:0]  bram_wea,
  output logic [16:0] bram_addr,
  output logic [31:0] bram_din,
  output logic        busy,
  output logic        frame_done,
  output logic        timeout_err
);

  // One counter serves the clear address, the engine reset pulse and the
  // run timeout, so it is sized for the largest of the three.
  localparam int CMAX_A = (FB_WORDS > ENG_RST_CYCLES) ? FB_WORDS : ENG_RST_CYCLES;
  localparam int CMAX   = (CMAX_A > TIMEOUT_CYCLES) ? CMAX_A : TIMEOUT_CYCLES;
  localparam int CW     = $clog2(CMAX + 1);
  localparam int DW     = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ERST,
    S_RUN,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]  zoom_q, zoom_d;
  logic [3:0]  wea_q, wea_d;
  logic [16:0] addr_q, addr_d;
  logic [31:0] din_q, din_d;
  logic        terr_q, terr_d;
  logic        pend_q, pend_d;
  logic        pdir_q, pdir_d;
  logic        rdy_q, rdy_d;
  logic [1:0]  nz;

  // Button conditioning
  logic [1:0]    sync_q;
  logic          db_q;
  logic [DW-1:0] db_cnt_q;
  logic          cmd;

  // The debounced level follows the synchronized button only after it has
  // disagreed for DEBOUNCE_CYCLES consecutive cycles; agreeing resets the run.
  assign cmd = sync_q[1] && !db_q && (db_cnt_q == DW'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= 2'b00;
      db_q     <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      sync_q <= {sync_q[0], btn_zoom};
      if (sync_q[1] != db_q) begin
        if (db_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
          db_q     <= sync_q[1];
          db_cnt_q <= '0;
        end else begin
          db_cnt_q <= db_cnt_q + DW'(1);
        end
      end else begin
        db_cnt_q <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
      zoom_q  <= 2'd0;
      wea_q   <= 4'h0;
      addr_q  <= 17'd0;
      din_q   <= 32'd0;
      terr_q  <= 1'b0;
      pend_q  <= 1'b0;
      pdir_q  <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      zoom_q  <= zoom_d;
      wea_q   <= wea_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      terr_q  <= terr_d;
      pend_q  <= pend_d;
      pdir_q  <= pdir_d;
      rdy_q   <= rdy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    zoom_d  = zoom_q;
    wea_d   = 4'h0;
    addr_d  = addr_q;
    din_d   = din_q;
    terr_d  = terr_q;
    pend_d  = pend_q;
    pdir_d  = pdir_q;
    rdy_d   = rdy_q;
    nz      = zoom_q;

    case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          pend_d = 1'b0;
          if (pdir_q) begin
            nz = (zoom_q == 2'(MAX_ZOOM)) ? zoom_q : zoom_q + 2'd1;
          end else begin
            nz = (zoom_q == 2'd0) ? zoom_q : zoom_q - 2'd1;
          end
          // A saturated request leaves the current picture untouched.
          if (nz != zoom_q) begin
            zoom_d  = nz;
            state_d = S_CLEAR;
            cnt_d   = '0;
          end
        end
      end
      S_CLEAR: begin
        wea_d  = 4'hF;
        addr_d = 17'(cnt_q);
        din_d  = CLEAR_WORD;
        if (cnt_q == CW'(FB_WORDS - 1)) begin
          state_d = S_ERST;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_ERST: begin
        if (cnt_q == CW'(ENG_RST_CYCLES - 1)) begin
          state_d = S_RUN;
          cnt_d   = '0;
          // Preset so a ready left high by the previous render is not an edge.
          rdy_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RUN: begin
        wea_d  = eng_wea;
        addr_d = eng_addr;
        din_d  = eng_dout;
        rdy_d  = eng_ready;
        if (eng_ready && !rdy_q) begin
          state_d = S_DONE;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          terr_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A fresh press wins over a pending slot being consumed this cycle.
    if (cmd) begin
      pend_d = 1'b1;
      pdir_d = sw_dir;
    end
  end

  assign zoom_level  = zoom_q;
  assign eng_rst     = (state_q == S_CLEAR) || (state_q == S_ERST);
  assign bram_wea    = wea_q;
  assign bram_addr   = addr_q;
  assign bram_din    = din_q;
  assign busy        = (state_q != S_IDLE);
  assign frame_done  = (state_q == S_DONE);
  assign timeout_err = terr_q;

endmodule

// File: doc/render_scheduler.md
Name: render_scheduler

Overview:
Sequences the Mandelbrot engine and owns the framebuffer BRAM write port (port A, clk domain). It debounces the zoom button and keeps the saturating zoom level. On every effective zoom change it clears the framebuffer, resets and restarts the engine, and forwards engine writes to BRAM until the engine reports ready. It sits between the button/switch inputs, the MBT engine and BRAM port A, and replaces the ad-hoc zoom, reset and write-register logic at top level.

Parameters:
DEBOUNCE_CYCLES, 1000000, cycles the synchronized button must be stable (10 ms at 100 MHz)
FB_WORDS, 120000, framebuffer depth in 32-bit words (800x600 / 4 pixels per word)
ENG_RST_CYCLES, 16, engine reset pulse length after clear
TIMEOUT_CYCLES, 67108864, maximum RUN duration before abort
MAX_ZOOM, 3, highest zoom level
CLEAR_WORD, 32'h00000000, fill value written during clear

Ports:
clk  in  1  system clock (100 MHz)
rst  in  1  asynchronous reset, active-high
btn_zoom  in  1  raw zoom button, asynchronous
sw_dir  in  1  1 = zoom in, 0 = zoom out; sampled on debounced press
eng_wea  in  4  engine byte write enables
eng_addr  in  17  engine word address
eng_dout  in  32  engine write data
eng_ready  in  1  engine render-complete level
zoom_level  out  2  current zoom level to engine
eng_rst  out  1  engine reset
bram_wea  out  4  BRAM port A byte write enables (registered)
bram_addr  out  17  BRAM port A address (registered)
bram_din  out  32  BRAM port A data (registered)
busy  out  1  high outside IDLE
frame_done  out  1  one-cycle pulse when a render ends
timeout_err  out  1  sticky; set when RUN times out

Behaviour:
- Reset (async assert, sync release): state=CLEAR, clear counter=0, zoom_level=0, eng_rst=1, bram_wea=0, bram_addr=0, bram_din=0, busy=1, frame_done=0, timeout_err=0, pending=0, debounce state cleared. A full render follows every reset.
- Button path: 2-flop synchronizer, then a stability counter that reloads on any change. The debounced level updates after DEBOUNCE_CYCLES stable cycles. A 0->1 edge of the debounced level is a command; sw_dir is captured in that cycle.
- Commands: one-deep pending slot (pending flag plus direction). A new command overwrites the stored direction (last wins). Commands are accepted in any state.
- States:
  - IDLE: busy=0, eng_rst=0, bram_wea=0. If pending: clear pending and compute the new zoom (in: min(z+1,MAX_ZOOM); out: max(z-1,0)). If the new zoom differs, update zoom_level and go to CLEAR next cycle. Otherwise stay in IDLE with no render.
  - CLEAR: eng_rst=1. Each cycle register bram_wea=4'hF, bram_addr=counter, bram_din=CLEAR_WORD, then counter++. After address FB_WORDS-1 is issued, go to ERST (exactly FB_WORDS writes). The counter resets to 0 on CLEAR entry.
  - ERST: eng_rst=1, bram_wea=0 for ENG_RST_CYCLES cycles, then RUN. eng_rst deasserts on RUN entry.
  - RUN: eng_rst=0. Each cycle, bram_* <= eng_* (1-cycle registered pass-through, including the cycle eng_ready rises).
    - Exit on an eng_ready 0->1 edge. The edge detector is preset to 1 on RUN entry, so a ready still high from the previous render is ignored until it falls.
    - Timeout counter starts at 0 on entry. When it reaches TIMEOUT_CYCLES-1 without the edge, set timeout_err and go to DONE.
  - DONE: 1 cycle. frame_done=1. bram_wea shows the last captured engine write, then 0 from IDLE. Next state IDLE.
- zoom_level changes only on the IDLE->CLEAR transition, so it is stable for the whole render.
- Engine writes are never forwarded outside RUN. In all other states bram_wea is 0 except during CLEAR writes.
- timeout_err is cleared only by rst.
- Async rst in any state aborts immediately. Outputs take reset values and the render restarts from CLEAR with zoom_level=0.

Test Plan:
- Reset, DEBOUNCE_CYCLES=4, FB_WORDS=8, ENG_RST_CYCLES=4 -> 8 writes wea=F, addr 0..7, data 0. eng_rst high for 12 cycles, then low. eng_ready edge -> frame_done pulses once, busy falls next cycle.
- In IDLE at zoom 0, hold btn_zoom with sw_dir=1 for 10 cycles -> exactly one command, zoom_level=1 at CLEAR entry, full clear/ERST/RUN sequence. Bounce shorter than 4 cycles -> no command.
- At zoom 3, press zoom-in -> no state change, busy stays 0, no BRAM writes. At zoom 0, press zoom-out -> same.
- During RUN at zoom 1, press in, then out -> after DONE, one render at zoom 0 (last wins). No second render follows.
- In RUN, drive eng_wea=F, addr=0x155, dout=0xDEADBEEF -> BRAM port shows the same values exactly one cycle later. Same stimulus in IDLE -> bram_wea stays 0.
- TIMEOUT_CYCLES=32 with eng_ready held 0 -> timeout_err=1 and frame_done at RUN cycle 32. Assert rst mid-CLEAR -> outputs reset within the cycle and the clear restarts at addr 0.
